// File: rtl/pc_next_unit_pkg.sv
// Shared next-PC definitions: redirect-source codes and
// processor-wide fetch defaults.
package pc_next_unit_pkg;

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_JMP = 2'd2;
    localparam logic [1:0] SRC_RET = 2'd3;

    localparam int DEF_INSTR_BYTES = 4;
    localparam longint unsigned DEF_RESET_PC = 64'h0;

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch redirect bus between decode/execute and the next-PC unit.
// The master issues redirects and stalls; the slave owns the PC.
interface pc_next_unit_if #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16
);

    logic              stall;
    logic              branch_taken;
    logic [IMM_W-1:0]  imm;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic [ADDR_W-1:0] branch_target;
    logic              pending;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_underflow;

    modport master (
        output stall, branch_taken, imm, jump, jump_target, call, ret,
        input  pc, pc_next_seq, branch_target, pending,
        input  ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, imm, jump, jump_target, call, ret,
        output pc, pc_next_seq, branch_target, pending,
        output ras_empty, ras_full, ras_underflow
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the
// oldest entry, and push+pop together replaces the top in place.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    count;

    assign top_idx  = ptr - PW'(1);
    assign top_data = mem[top_idx];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop && !empty) begin
            mem[top_idx] <= push_data;
        end else if (push) begin
            // ptr wraps onto the oldest slot once the stack is full
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-stage next-PC generator: owns the PC, arbitrates redirects,
// holds a redirect across stalls and keeps a return-address stack.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              IMM_W       = 16,
    parameter int              IMM_SHIFT   = 2,
    parameter int              INSTR_BYTES = DEF_INSTR_BYTES,
    parameter longint unsigned RESET_PC    = DEF_RESET_PC,
    parameter int              RAS_DEPTH   = 4
) (
    input logic          clk,
    input logic          reset,
    pc_next_unit_if.slave bus
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] pend_tgt;
    logic [ADDR_W-1:0] ras_top;
    logic [1:0]        src;
    logic              req;
    logic              pend_q;
    logic              und_q;
    logic              ras_empty;
    logic              ras_full;

    assign offset = {{(ADDR_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} << IMM_SHIFT;
    assign seq    = pc_q + ADDR_W'(INSTR_BYTES);
    assign br_tgt = seq + offset;

    // Sources overlap, so the first match wins
    always_comb begin
        src = SRC_SEQ;
        priority case (1'b1)
            bus.ret:          src = SRC_RET;
            bus.jump:         src = SRC_JMP;
            bus.branch_taken: src = SRC_BR;
            default:          src = SRC_SEQ;
        endcase
    end

    always_comb begin
        tgt = seq;
        case (src)
            SRC_RET: tgt = ras_empty ? bus.jump_target : ras_top;
            SRC_JMP: tgt = bus.jump_target;
            SRC_BR:  tgt = br_tgt;
            default: tgt = seq;
        endcase
    end

    assign req = (src != SRC_SEQ);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.call & bus.jump),
        .pop       (bus.ret),
        .push_data (seq),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= ADDR_W'(RESET_PC);
            pend_q   <= 1'b0;
            pend_tgt <= '0;
            und_q    <= 1'b0;
        end else begin
            und_q <= bus.ret & ras_empty;
            if (!bus.stall) begin
                pend_q <= 1'b0;
                if (req)
                    pc_q <= tgt;
                else if (pend_q)
                    pc_q <= pend_tgt;
                else
                    pc_q <= seq;
            end else if (req) begin
                pend_q   <= 1'b1;
                pend_tgt <= tgt;
            end
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_next_seq   = seq;
    assign bus.branch_target = br_tgt;
    assign bus.pending       = pend_q;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_underflow = und_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: vector table for redirect and
// stall behaviour plus hand sequences for the return stack and reset.
module tb_pc_next_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_next_unit_if #(.ADDR_W(32), .IMM_W(16)) bus ();

    pc_next_unit #(
        .ADDR_W      (32),
        .IMM_W       (16),
        .IMM_SHIFT   (2),
        .INSTR_BYTES (4),
        .RESET_PC    (0),
        .RAS_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] pc;
        logic        pend;
    } vec_t;

    vec_t v [17];

    task automatic set_in(input logic st, input logic br,
                          input logic [15:0] im, input logic jp,
                          input logic [31:0] jt, input logic cl,
                          input logic rt);
        bus.stall        = st;
        bus.branch_taken = br;
        bus.imm          = im;
        bus.jump         = jp;
        bus.jump_target  = jt;
        bus.call         = cl;
        bus.ret          = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    initial begin
        v[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        32'h4,        32'h4,        1'b0};
        v[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        32'h8,        32'h8,        1'b0};
        v[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        32'hC,        32'hC,        1'b0};
        v[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 32'h100,      32'h10,       32'h100,      1'b0};
        v[4]  = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 32'h0,        32'hFC,       32'hFC,       1'b0};
        v[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 32'h100,      32'h100,      32'h100,      1'b0};
        v[6]  = '{1'b0, 1'b1, 16'h7FFF, 1'b0, 32'h0,        32'h20100,    32'h20100,    1'b0};
        v[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 32'h200,      32'h20104,    32'h200,      1'b0};
        v[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 32'h4000,     32'h204,      32'h200,      1'b1};
        v[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0,        32'h204,      32'h200,      1'b1};
        v[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0,        32'h204,      32'h200,      1'b1};
        v[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        32'h204,      32'h4000,     1'b0};
        v[12] = '{1'b1, 1'b1, 16'h0004, 1'b0, 32'h0,        32'h4014,     32'h4000,     1'b1};
        v[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 32'h5000,     32'h4004,     32'h4000,     1'b1};
        v[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 32'h6000,     32'h4004,     32'h6000,     1'b0};
        v[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 32'hFFFFFFFC, 32'h6004,     32'hFFFFFFFC, 1'b0};
        v[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0};

        reset = 1'b1;
        set_in(0, 0, 16'h0, 0, 32'h0, 0, 0);
        repeat (2) step();
        reset = 1'b0;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_pend", {31'b0, bus.pending}, 32'h0);
        chk("rst_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("rst_full", {31'b0, bus.ras_full}, 32'h0);
        chk("rst_und", {31'b0, bus.ras_underflow}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            set_in(v[i].stall, v[i].br, v[i].imm, v[i].jmp, v[i].jt, 0, 0);
            #1;
            chk($sformatf("vec%0d_bt", i), bus.branch_target, v[i].bt);
            step();
            chk($sformatf("vec%0d_pc", i), bus.pc, v[i].pc);
            chk($sformatf("vec%0d_pend", i), {31'b0, bus.pending}, {31'b0, v[i].pend});
        end

        set_in(0, 0, 16'h0, 1, 32'h10, 0, 0);
        step();
        chk("ras_setup_pc", bus.pc, 32'h10);
        for (int k = 1; k <= 5; k++) begin
            set_in(0, 0, 16'h0, 1, 32'(k * 16 + 16), 1, 0);
            step();
            chk($sformatf("call%0d_pc", k), bus.pc, 32'(k * 16 + 16));
            if (k == 3)
                chk("call3_full", {31'b0, bus.ras_full}, 32'h0);
        end
        chk("call5_full", {31'b0, bus.ras_full}, 32'h1);
        chk("call5_empty", {31'b0, bus.ras_empty}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 16'h0, 0, 32'h900, 0, 1);
            step();
            chk($sformatf("ret%0d_pc", k), bus.pc, 32'h54 - 32'(k * 16));
            chk($sformatf("ret%0d_und", k), {31'b0, bus.ras_underflow}, 32'h0);
        end
        step();
        chk("ret_uf_pc", bus.pc, 32'h900);
        chk("ret_uf_pulse", {31'b0, bus.ras_underflow}, 32'h1);
        chk("ret_uf_empty", {31'b0, bus.ras_empty}, 32'h1);
        set_in(0, 0, 16'h0, 0, 32'h0, 0, 0);
        step();
        chk("uf_clear", {31'b0, bus.ras_underflow}, 32'h0);
        chk("uf_idle_pc", bus.pc, 32'h904);

        set_in(0, 0, 16'h0, 1, 32'h3FC, 0, 0);
        step();
        set_in(0, 0, 16'h0, 1, 32'h7FC, 1, 0);
        step();
        set_in(0, 0, 16'h0, 1, 32'h1000, 1, 0);
        step();
        chk("pri_pre_pc", bus.pc, 32'h1000);
        set_in(0, 1, 16'h0008, 1, 32'h2000, 0, 1);
        step();
        chk("pri_pc", bus.pc, 32'h800);
        chk("pri_empty", {31'b0, bus.ras_empty}, 32'h0);
        set_in(0, 0, 16'h0, 0, 32'h900, 0, 1);
        step();
        chk("pri_pop_pc", bus.pc, 32'h400);
        chk("pri_pop_empty", {31'b0, bus.ras_empty}, 32'h1);

        set_in(0, 0, 16'h0, 1, 32'hA00, 1, 1);
        step();
        chk("cr_empty_pc", bus.pc, 32'hA00);
        chk("cr_empty_und", {31'b0, bus.ras_underflow}, 32'h1);
        chk("cr_empty_push", {31'b0, bus.ras_empty}, 32'h0);
        set_in(0, 0, 16'h0, 0, 32'h0, 0, 1);
        step();
        chk("cr_pop_pc", bus.pc, 32'h404);
        chk("cr_pop_und", {31'b0, bus.ras_underflow}, 32'h0);
        set_in(0, 0, 16'h0, 1, 32'hB00, 1, 0);
        step();
        set_in(0, 0, 16'h0, 1, 32'hC00, 1, 1);
        step();
        chk("cr_swap_pc", bus.pc, 32'h408);
        set_in(0, 0, 16'h0, 0, 32'h0, 0, 1);
        step();
        chk("cr_swap_pop", bus.pc, 32'hB04);
        chk("cr_swap_empty", {31'b0, bus.ras_empty}, 32'h1);

        set_in(0, 0, 16'h0, 0, 32'h0, 1, 0);
        step();
        chk("call_nojmp_pc", bus.pc, 32'hB08);
        chk("call_nojmp_empty", {31'b0, bus.ras_empty}, 32'h1);

        set_in(1, 0, 16'h0, 1, 32'h3000, 0, 0);
        step();
        chk("rs_pend_set", {31'b0, bus.pending}, 32'h1);
        chk("rs_pc_hold", bus.pc, 32'hB08);
        reset = 1'b1;
        set_in(1, 0, 16'h0, 0, 32'h0, 0, 0);
        step();
        chk("rs_pc", bus.pc, 32'h0);
        chk("rs_pend", {31'b0, bus.pending}, 32'h0);
        reset = 1'b0;
        set_in(0, 0, 16'h0, 0, 32'h0, 0, 0);
        step();
        chk("rs_after_pc", bus.pc, 32'h4);
        chk("rs_after_pend", {31'b0, bus.pending}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
